fpu_op_ctrl: RTL

Sequencing controller for the single-precision FPU in the execute stage. It registers the OP-FP fields of an accepted instruction and decodes them into the FPU datapath select code, including fcvt.w.s, which the previous purely combinational decode did not cover. It resolves the dynamic rounding mode and flags illegal encodings. It also tracks per-class execution latency with a counter and a valid/ready handshake, and steers the result to the integer or FP register file.

---
 rtl/fpu_op_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fpu_op_ctrl.sv
// OP-FP sequencing controller: registers and decodes an accepted instruction,
// resolves the rounding mode, and times the per-class execution latency.
module fpu_op_ctrl #(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 4,
    parameter int SMP_LAT = 1,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] funct5,
    input  logic [2:0] rm,
    input  logic [4:0] rs2,
    input  logic [2:0] frm,
    output logic       start,
    output logic [4:0] sel,
    output logic [2:0] rm_eff,
    output logic       cvt_unsigned,
    output logic       wb_int,
    output logic       illegal,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [1:0] {C_ADD, C_MUL, C_SMP} lat_class_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start;
    logic [4:0]       r_sel;
    logic [2:0]       r_rm_eff;
    logic             r_cvt;
    logic             r_wb;
    logic             r_illegal;

    lat_class_t       w_cls;
    logic [4:0]       w_sel;
    logic             w_wb;
    logic             w_match;
    logic             w_rnd;
    logic             w_cvt;
    logic [2:0]       w_rm_eff;
    logic             w_illegal;
    logic [CNT_W-1:0] w_lat;
    logic             w_accept;

    assign w_rm_eff  = (rm == 3'b111) ? frm : rm;
    // Only rounding ops reject the reserved modes 101/110.
    assign w_illegal = ~w_match | (w_rnd & ((w_rm_eff == 3'b101) | (w_rm_eff == 3'b110)));
    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;

    always_comb begin
        w_sel   = '0;
        w_cls   = C_SMP;
        w_wb    = 1'b0;
        w_match = 1'b0;
        w_rnd   = 1'b0;
        w_cvt   = 1'b0;
        case (funct5)
            5'b00000: begin w_match = 1'b1; w_sel = 5'd4; w_cls = C_ADD; w_rnd = 1'b1; end
            5'b00001: begin w_match = 1'b1; w_sel = 5'd5; w_cls = C_ADD; w_rnd = 1'b1; end
            5'b00010: begin w_match = 1'b1; w_sel = 5'd6; w_cls = C_MUL; w_rnd = 1'b1; end
            5'b00101: begin
                if (rm == 3'b000) begin w_match = 1'b1; w_sel = 5'd7; end
                else if (rm == 3'b001) begin w_match = 1'b1; w_sel = 5'd8; end
            end
            5'b10100: begin
                w_wb = 1'b1;
                case (rm)
                    3'b010:  begin w_match = 1'b1; w_sel = 5'd9;  end
                    3'b001:  begin w_match = 1'b1; w_sel = 5'd10; end
                    3'b000:  begin w_match = 1'b1; w_sel = 5'd11; end
                    default: ;
                endcase
            end
            5'b11110: begin w_match = (rm == 3'b000); w_sel = 5'd12; end
            5'b11100: begin w_match = (rm == 3'b000); w_sel = 5'd13; w_wb = 1'b1; end
            5'b11010: begin
                w_match = (rs2[4:1] == 4'b0000); w_sel = 5'd14;
                w_cls = C_ADD; w_rnd = 1'b1; w_cvt = 1'b1;
            end
            5'b11000: begin
                w_match = (rs2[4:1] == 4'b0000); w_sel = 5'd15; w_wb = 1'b1;
                w_cls = C_ADD; w_rnd = 1'b1; w_cvt = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_cls)
            C_ADD:   w_lat = CNT_W'(ADD_LAT - 1);
            C_MUL:   w_lat = CNT_W'(MUL_LAT - 1);
            default: w_lat = CNT_W'(SMP_LAT - 1);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_illegal ? S_DONE : S_EXEC;
            S_EXEC: if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = w_accept ? (w_illegal ? S_DONE : S_EXEC) : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_start   <= 1'b0;
            r_sel     <= '0;
            r_rm_eff  <= '0;
            r_cvt     <= 1'b0;
            r_wb      <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_start <= w_accept & ~w_illegal;
            if (w_accept) begin
                r_cnt     <= w_lat;
                r_sel     <= w_illegal ? 5'd0 : w_sel;
                r_rm_eff  <= w_rm_eff;
                r_cvt     <= ~w_illegal & w_cvt & rs2[0];
                r_wb      <= ~w_illegal & w_wb;
                r_illegal <= w_illegal;
            end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign start        = r_start;
    assign sel          = r_sel;
    assign rm_eff       = r_rm_eff;
    assign cvt_unsigned = r_cvt;
    assign wb_int       = r_wb;
    assign illegal      = r_illegal;
    assign out_valid    = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);

endmodule
